// File: rtl/ad7864_pkg.sv
// Shared state encoding and widths for the AD7864 frame reader and its output FIFO.
package ad7864_pkg;

    localparam int WORD_W   = 16;
    localparam int CH_W     = 2;
    localparam int SAMPLE_W = 12;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_LOW  = 2'd1,
        RD_HIGH = 2'd2,
        DONE    = 2'd3
    } rd_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; pointers carry one extra wrap bit to tell full from empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    // A pop in the same cycle frees the head slot, so a full FIFO can still take the word.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_drop  = i_push && !w_do_push;

endmodule

// File: rtl/ad7864_reader.sv
// AD7864 frame reader: after db_rdy, strobes NUM_CH channels over the parallel bus and queues them.
// Define AD7864_READER_CHTAG_EN to tag each word with its channel index instead of sign-extending.
module ad7864_reader
    import ad7864_pkg::*;
#(
    parameter int RD_LO      = 2,
    parameter int RD_HI      = 1,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                clkin,
    input  logic                rst_bar,
    input  logic                db_rdy,
    input  logic [SAMPLE_W-1:0] adc_db,
    output logic                adc_cs_bar,
    output logic                adc_rd_bar,
    input  logic                dsp_pop,
    output logic [WORD_W-1:0]   dsp_data,
    output logic                fifo_empty,
    output logic                fifo_full,
    input  logic                ovf_clr,
    output logic                fifo_ovf,
    output logic                trig_miss,
    output logic                busy
);
    localparam int CNT_MAX = (RD_LO > RD_HI) ? RD_LO : RD_HI;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(RD_LO - 1);
    localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(RD_HI - 1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);

    rd_state_e         r_state;
    rd_state_e         w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CH_W-1:0]   r_ch;
    logic [CH_W-1:0]   w_ch_nxt;
    logic              w_sample;
    logic              w_busy;
    logic              w_drop;
    logic              r_armed;
    logic              r_cs_bar;
    logic              r_rd_bar;
    logic              r_push;
    logic              r_ovf;
    logic              r_miss;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word;

    assign w_busy = (r_state != IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ch_nxt    = r_ch;
        w_sample    = 1'b0;
        case (r_state)
            IDLE: begin
                if (db_rdy && r_armed) begin
                    w_state_nxt = RD_LOW;
                    w_cnt_nxt   = '0;
                    w_ch_nxt    = '0;
                end
            end
            RD_LOW: begin
                if (r_cnt == LO_LAST) begin
                    w_sample    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_ch == CH_LAST) ? DONE : RD_HIGH;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RD_HIGH: begin
                if (r_cnt == HI_LAST) begin
                    w_cnt_nxt   = '0;
                    w_ch_nxt    = r_ch + CH_W'(1);
                    w_state_nxt = RD_LOW;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef AD7864_READER_CHTAG_EN
    assign w_word = {r_ch, 2'b00, adc_db};
`else
    assign w_word = {{(WORD_W - SAMPLE_W){adc_db[SAMPLE_W-1]}}, adc_db};
`endif

    // Strobes are registered from the next state so the ADC never sees decode glitches.
    always_ff @(posedge clkin or negedge rst_bar) begin
        if (!rst_bar) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ch     <= '0;
            r_armed  <= 1'b0;
            r_cs_bar <= 1'b1;
            r_rd_bar <= 1'b1;
            r_push   <= 1'b0;
            r_word   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ch     <= w_ch_nxt;
            r_armed  <= 1'b1;
            r_cs_bar <= (w_state_nxt == IDLE) || (w_state_nxt == DONE);
            r_rd_bar <= (w_state_nxt != RD_LOW);
            r_push   <= w_sample;
            if (w_sample) r_word <= w_word;
        end
    end

    // Sticky flags: a new set event beats a clear in the same cycle.
    always_ff @(posedge clkin or negedge rst_bar) begin
        if (!rst_bar) begin
            r_ovf  <= 1'b0;
            r_miss <= 1'b0;
        end else begin
            if (w_drop)                r_ovf <= 1'b1;
            else if (ovf_clr)          r_ovf <= 1'b0;
            if (db_rdy && w_busy)      r_miss <= 1'b1;
            else if (ovf_clr)          r_miss <= 1'b0;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clkin),
        .i_rst_n (rst_bar),
        .i_push  (r_push),
        .i_wdata (r_word),
        .i_pop   (dsp_pop),
        .o_rdata (dsp_data),
        .o_empty (fifo_empty),
        .o_full  (fifo_full),
        .o_drop  (w_drop)
    );

    assign adc_cs_bar = r_cs_bar;
    assign adc_rd_bar = r_rd_bar;
    assign fifo_ovf   = r_ovf;
    assign trig_miss  = r_miss;
    assign busy       = w_busy;

endmodule
